// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths, op encoding
// and the read-response tracker states.
package ram_arb_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Which port, if any, owns the RAM read data arriving this cycle.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2
    } trk_state_e;

endpackage : ram_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way priority picker: a lone requester always wins; on contention the
// port that was not granted most recently (pointer = last winner) wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    // NOTE: every output gets a default before the if, so no latch is inferred.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = pointer ? 2'b01 : 2'b10;
        end
    end

endmodule : rr_arb2

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with 1-cycle read latency.
// Define RAM_ARB_RR_EN for round-robin contention; otherwise port 0 always wins.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  ram_request,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    logic [1:0] valid_vec;
    logic [1:0] grant;
    logic       pointer;
    trk_state_e trk_d, trk_q;

    // ready is combinational, so reset must mask the request path directly.
    assign valid_vec = {req1_valid, req0_valid} & {2{rst_n}};

    rr_arb2 u_rr_arb2 (
        .valid   (valid_vec),
        .pointer (pointer),
        .grant   (grant)
    );

`ifdef RAM_ARB_RR_EN
    logic last_grant_d, last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (|grant) begin
            last_grant_d = grant[1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign pointer = last_grant_q;
`else
    assign pointer = 1'b1;
`endif

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        ram_request    = OP_READ;
        ram_addr       = '0;
        ram_write_data = '0;
        if (grant[0]) begin
            ram_request    = req0_we;
            ram_addr       = req0_addr;
            ram_write_data = req0_wdata;
        end else if (grant[1]) begin
            ram_request    = req1_we;
            ram_addr       = req1_addr;
            ram_write_data = req1_wdata;
        end
    end

    always_comb begin
        trk_d = NONE;
        if (grant[0] && req0_we == OP_READ) begin
            trk_d = RD0;
        end else if (grant[1] && req1_we == OP_READ) begin
            trk_d = RD1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_q <= NONE;
        end else begin
            trk_q <= trk_d;
        end
    end

    assign rsp0_valid = (trk_q == RD0);
    assign rsp1_valid = (trk_q == RD1);
    assign rsp0_rdata = rsp0_valid ? ram_read_data : '0;
    assign rsp1_rdata = rsp1_valid ? ram_read_data : '0;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed scenarios plus random traffic against
// a queue/array reference model; works with or without RAM_ARB_RR_EN.
module tb_ram_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
`ifdef RAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        logic          valid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_rsp_t;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic          ram_request;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_write_data, ram_read_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int last_winner = 1;
    exp_rsp_t exp_q[$];
    logic [DW-1:0] ref_mem [int];

    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    bit            tb_wr  [0:(1<<AW)-1];

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_we        (req0_we),
        .req0_addr      (req0_addr),
        .req0_wdata     (req0_wdata),
        .req0_ready     (req0_ready),
        .rsp0_valid     (rsp0_valid),
        .rsp0_rdata     (rsp0_rdata),
        .req1_valid     (req1_valid),
        .req1_we        (req1_we),
        .req1_addr      (req1_addr),
        .req1_wdata     (req1_wdata),
        .req1_ready     (req1_ready),
        .rsp1_valid     (rsp1_valid),
        .rsp1_rdata     (rsp1_rdata),
        .ram_request    (ram_request),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Preloaded contents of never-written RAM words.
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        case (a)
            10'd1:   return 16'h000A;
            10'd2:   return 16'h000B;
            10'd3:   return 16'h000C;
            default: begin
                w = {{(DW-AW){1'b0}}, a};
                return (w * 16'h9E37) ^ 16'h5A5A;
            end
        endcase
    endfunction

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (ram_request) begin
            tb_mem[ram_addr] <= ram_write_data;
            tb_wr[ram_addr]  <= 1'b1;
        end
        ram_read_data <= tb_wr[ram_addr] ? tb_mem[ram_addr] : init_word(ram_addr);
    end

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(a);
    endfunction

    function automatic op_t idle_op();
        op_t o;
        o = '{1'b0, 1'b0, '0, '0};
        return o;
    endfunction

    function automatic op_t rd_op(input logic [AW-1:0] a);
        op_t o;
        o = '{1'b1, 1'b0, a, '0};
        return o;
    endfunction

    function automatic op_t wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o = '{1'b1, 1'b1, a, d};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // One cycle of stimulus: drive at negedge, check grant/RAM port, update model.
    task automatic step(input op_t o0, input op_t o1, output logic g0, output logic g1);
        int            w;
        op_t           win;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        @(negedge clk);
        req0_valid = o0.valid; req0_we = o0.we; req0_addr = o0.addr; req0_wdata = o0.data;
        req1_valid = o1.valid; req1_we = o1.we; req1_addr = o1.addr; req1_wdata = o1.data;
        #1;
        w = -1;
        if (o0.valid && o1.valid) w = (RR_EN && last_winner == 0) ? 1 : 0;
        else if (o0.valid)        w = 0;
        else if (o1.valid)        w = 1;
        check("req0_ready", 32'(req0_ready), 32'(w == 0));
        check("req1_ready", 32'(req1_ready), 32'(w == 1));
        e_req = 1'b0; e_addr = '0; e_wdata = '0;
        if (w >= 0) begin
            win     = (w == 0) ? o0 : o1;
            e_req   = win.we;
            e_addr  = win.addr;
            e_wdata = win.data;
            if (win.we) ref_mem[int'(win.addr)] = win.data;
            else        exp_q.push_back('{w, ref_read(win.addr), cycle + 1});
            last_winner = w;
        end
        check("ram_request",    32'(ram_request),    32'(e_req));
        check("ram_addr",       32'(ram_addr),       32'(e_addr));
        check("ram_write_data", 32'(ram_write_data), 32'(e_wdata));
        g0 = req0_ready;
        g1 = req1_ready;
    endtask

    // Response monitor: pops the scoreboard when a response is due this cycle.
    initial begin : monitor
        exp_rsp_t      e;
        logic          ev0, ev1;
        logic [DW-1:0] ed0, ed1;
        forever begin
            @(negedge clk);
            #2;
            ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
                e = exp_q.pop_front();
                if (e.port == 0) begin ev0 = 1'b1; ed0 = e.data; end
                else             begin ev1 = 1'b1; ed1 = e.data; end
            end
            check("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
            check("rsp0_rdata", 32'(rsp0_rdata), 32'(ed0));
            check("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
            check("rsp1_rdata", 32'(rsp1_rdata), 32'(ed1));
        end
    end

    initial begin : stim
        op_t  p0, p1;
        logic g0, g1;
        int   exp_w;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        #3;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("reset_req0_ready",  32'(req0_ready),  32'd0);
        check("reset_req1_ready",  32'(req1_ready),  32'd0);
        check("reset_ram_request", 32'(ram_request), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Sustained contention straight after reset.
        p0 = rd_op(10'd0);
        p1 = rd_op(10'd8);
        for (int i = 0; i < 6; i++) begin
            step(p0, p1, g0, g1);
            exp_w = RR_EN ? (i % 2) : 0;
            check("contention_grant0", 32'(g0), 32'(exp_w == 0));
            check("contention_grant1", 32'(g1), 32'(exp_w == 1));
            if (g0) p0.addr = p0.addr + 1'b1;
            if (g1) p1.addr = p1.addr + 1'b1;
        end

        // Idle: RAM port parked at zero.
        repeat (4) step(idle_op(), idle_op(), g0, g1);

        // Write through port 0, read back next cycle through port 1.
        step(wr_op(10'd5, 16'h1234), idle_op(), g0, g1);
        step(idle_op(), rd_op(10'd5), g0, g1);
        @(posedge clk);
        #1;
        check("wr_rd_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("wr_rd_rsp1_rdata", 32'(rsp1_rdata), 32'h1234);
        check("wr_rd_rsp0_valid", 32'(rsp0_valid), 32'd0);

        // Back-to-back reads of preloaded words.
        step(rd_op(10'd1), idle_op(), g0, g1);
        step(rd_op(10'd2), idle_op(), g0, g1);
        step(rd_op(10'd3), idle_op(), g0, g1);
        step(idle_op(), rd_op(10'd2), g0, g1);
        step(rd_op(10'd5), idle_op(), g0, g1);
        step(idle_op(), idle_op(), g0, g1);

        // Reset right after a read transfer drops its response.
        step(rd_op(10'd4), idle_op(), g0, g1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        last_winner = 1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("midreset_req0_ready",  32'(req0_ready),  32'd0);
        check("midreset_req1_ready",  32'(req1_ready),  32'd0);
        check("midreset_ram_request", 32'(ram_request), 32'd0);
        check("midreset_rsp0_valid",  32'(rsp0_valid),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) step(idle_op(), idle_op(), g0, g1);
        step(rd_op(10'd6), rd_op(10'd7), g0, g1);
        check("post_reset_grant0", 32'(g0), 32'd1);
        check("post_reset_grant1", 32'(g1), 32'd0);
        p1 = rd_op(10'd7);
        step(idle_op(), p1, g0, g1);

        // Random traffic; a requester holds its op until it is accepted.
        p0 = idle_op();
        p1 = idle_op();
        for (int i = 0; i < 400; i++) begin
            if (!p0.valid && $urandom_range(0, 9) < 6)
                p0 = ($urandom_range(0, 2) == 0) ? wr_op(AW'($urandom_range(0, 7)), DW'($urandom))
                                                 : rd_op(AW'($urandom_range(0, 7)));
            if (!p1.valid && $urandom_range(0, 9) < 6)
                p1 = ($urandom_range(0, 2) == 0) ? wr_op(AW'($urandom_range(0, 7)), DW'($urandom))
                                                 : rd_op(AW'($urandom_range(0, 7)));
            step(p0, p1, g0, g1);
            if (g0) p0 = idle_op();
            if (g1) p1 = idle_op();
        end

        repeat (3) step(idle_op(), idle_op(), g0, g1);
        @(negedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, RAM address width.
REQ-003 The block SHALL have clk, input, 1, sole clock, all state updates on posedge.
REQ-004 The block SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have reqN_valid, input, 1, requester N (N=0,1) has an operation pending.
REQ-006 The block SHALL have reqN_we, input, 1, 1=write, 0=read.
REQ-007 The block SHALL have reqN_addr, input, ADDR_WIDTH, target address.
REQ-008 The block SHALL have reqN_wdata, input, DATA_WIDTH, write data.
REQ-009 The block SHALL have reqN_ready, output, 1, requester N's operation is issued this cycle.
REQ-010 The block SHALL have rspN_valid, output, 1, read data for requester N is valid this cycle.
REQ-011 The block SHALL have rspN_rdata, output, DATA_WIDTH, read data for requester N.
REQ-012 The block SHALL have ram_request, output, 1, RAM op select: 1=write, 0=read.
REQ-013 The block SHALL have ram_addr, output, ADDR_WIDTH, RAM address.
REQ-014 The block SHALL have ram_write_data, output, DATA_WIDTH, RAM write data.
REQ-015 The block SHALL have ram_read_data, input, DATA_WIDTH, registered RAM read data, valid one cycle after a read is issued.

Function
REQ-016 The block SHALL accept at most one operation per cycle; transfer occurs when reqN_valid and reqN_ready are both 1.
REQ-017 reqN_ready SHALL be combinational from the valid inputs and the priority pointer; the requester SHALL hold valid, we, addr and wdata stable until ready.
REQ-018 When only one requester is valid, it SHALL be granted in the same cycle (zero-wait).
REQ-019 When both requesters are valid, the requester not granted most recently SHALL win (round-robin); pointer last_grant updates only on a transfer.
REQ-020 On a granted cycle, ram_request, ram_addr and ram_write_data SHALL equal the winner's we, addr and wdata.
REQ-021 When idle (no transfer), ram_request SHALL be 0 (harmless read), ram_addr 0, ram_write_data 0.
REQ-022 Read-response tracker states: NONE, RD0, RD1; a read transfer by N moves to RDN at the next edge; otherwise to NONE.
REQ-023 In state RDN, rspN_valid SHALL be 1 and rspN_rdata SHALL equal ram_read_data; the other rsp_valid SHALL be 0; read latency is exactly 1 cycle after transfer.
REQ-024 Back-to-back reads (any mix of requesters) SHALL give one response per cycle in issue order with no bubble.
REQ-025 rspN_rdata SHALL be 0 when rspN_valid is 0.
REQ-026 A write followed by a read of the same address in the next cycle SHALL return the new data.
REQ-027 Writes SHALL produce no response.

Reset
REQ-028 While rst_n is 0: all reqN_ready, rspN_valid, ram_request SHALL be 0; last_grant resets to 1 (so port 0 wins first contention); tracker resets to NONE.
REQ-029 Reset asserted mid-operation SHALL drop any pending response; no rsp_valid appears after reset deasserts until a new read transfer.

Configuration
REQ-030 With RAM_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-019.
REQ-031 Without RAM_ARB_RR_EN, port 0 SHALL always win contention; last_grant is not implemented.

Structure
REQ-032 A shared package ram_arb_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, op constants OP_READ=0/OP_WRITE=1 and the tracker state enum.
REQ-033 The two-way priority picker SHALL be a sub-module rr_arb2 (valid[1:0], pointer -> one-hot grant).

Verification
REQ-034 Write 0x1234 to addr 5 via port 0, then read addr 5 via port 1 -> rsp1_valid one cycle after read transfer, rsp1_rdata=0x1234, rsp0_valid=0.
REQ-035 Both ports continuously valid for 6 cycles after reset (RR build) -> grants 0,1,0,1,0,1; fixed build -> grants 0 x6, req1_ready=0 throughout.
REQ-036 Port 0 reads addr 1,2,3 back-to-back (preloaded 0xA,0xB,0xC) -> rsp0_valid high 3 consecutive cycles with 0xA,0xB,0xC.
REQ-037 No requests -> ram_request=0, ram_addr=0, ram_write_data=0 every cycle.
REQ-038 rst_n asserted in cycle after a read transfer -> rsp_valid stays 0 and no response after release; first contention after release grants port 0.
